// File: rtl/led_cube_pkg.sv
// Shared constants and helpers for the LED cube driver: FSM/shifter state codes,
// counter sizing and the frame pattern ROM.
package led_cube_pkg;

    localparam int unsigned CUBE_EDGE = 8;
    localparam int unsigned LEDR_W    = 10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_LATCH   = 2'd2;
    localparam logic [1:0] ST_DISPLAY = 2'd3;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_LO    = 2'd1;
    localparam logic [1:0] PH_HI    = 2'd2;
    localparam logic [1:0] PH_LATCH = 2'd3;

    // Bits needed to count 0..limit-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

    // Frame ROM: every column of layer l is lit when l == f mod n, giving a rising plane.
    function automatic logic frame_lit(input int unsigned f, input int unsigned l,
                                       input int unsigned n);
        return l == (f % n);
    endfunction

endpackage

// File: rtl/led_cube_shifter.sv
// Serialises one column word MSB first onto SER/SRCLK, then pulses RCLK to latch it.
module led_cube_shifter
    import led_cube_pkg::*;
#(
    parameter int unsigned COLS    = 64,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [COLS-1:0] word,
    output logic            ser,
    output logic            srclk,
    output logic            rclk,
    output logic            shift_done_c,
    output logic            latch_done_c
);
    localparam int unsigned DW = cnt_width(CLK_DIV);
    localparam int unsigned IW = cnt_width(COLS);

    logic [1:0]      phase_q, phase_d;
    logic [DW-1:0]   div_q, div_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [COLS-1:0] sreg_q, sreg_d;
    logic            ser_q, ser_d, srclk_q, srclk_d, rclk_q, rclk_d;
    logic            tick;

    always_comb begin
        phase_d      = phase_q;
        div_d        = div_q;
        idx_d        = idx_q;
        sreg_d       = sreg_q;
        ser_d        = ser_q;
        srclk_d      = srclk_q;
        rclk_d       = rclk_q;
        shift_done_c = 1'b0;
        latch_done_c = 1'b0;
        tick         = (div_q == DW'(CLK_DIV - 1));
        if (abort) begin
            phase_d = PH_IDLE;
            div_d   = '0;
            idx_d   = '0;
            ser_d   = 1'b0;
            srclk_d = 1'b0;
            rclk_d  = 1'b0;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    if (start) begin
                        sreg_d  = word;
                        ser_d   = word[COLS-1];
                        srclk_d = 1'b0;
                        div_d   = '0;
                        idx_d   = '0;
                        phase_d = PH_LO;
                    end
                end
                PH_LO: begin
                    if (tick) begin
                        srclk_d = 1'b1;
                        div_d   = '0;
                        phase_d = PH_HI;
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                PH_HI: begin
                    if (tick) begin
                        srclk_d = 1'b0;
                        div_d   = '0;
                        if (idx_q == IW'(COLS - 1)) begin
                            rclk_d       = 1'b1;
                            phase_d      = PH_LATCH;
                            shift_done_c = 1'b1;
                        end else begin
                            idx_d   = idx_q + IW'(1);
                            sreg_d  = sreg_q << 1;
                            ser_d   = sreg_q[COLS-2];
                            phase_d = PH_LO;
                        end
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                default: begin
                    if (tick) begin
                        rclk_d       = 1'b0;
                        div_d        = '0;
                        phase_d      = PH_IDLE;
                        latch_done_c = 1'b1;
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            sreg_q  <= '0;
            ser_q   <= 1'b0;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            sreg_q  <= sreg_d;
            ser_q   <= ser_d;
            srclk_q <= srclk_d;
            rclk_q  <= rclk_d;
        end
    end

    assign ser   = ser_q;
    assign srclk = srclk_q;
    assign rclk  = rclk_q;

endmodule

// File: rtl/led_cube_multi_frame.sv
// 8x8x8 LED cube top: key synchronisers, layer-multiplex FSM, layer/scan/frame counters
// and the 74HC595 chain shifter.
module led_cube_multi_frame
    import led_cube_pkg::*;
#(
    parameter int unsigned CUBE_N     = CUBE_EDGE,
    parameter int unsigned NUM_FRAMES = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned LAYER_HOLD = 50000,
    parameter int unsigned FRAME_HOLD = 250
) (
    input  logic              CLOCK_50,
    input  logic [3:0]        KEY,
    output logic              SER,
    output logic              SRCLK,
    output logic              RCLK,
    output logic              OE_N,
    output logic [CUBE_N-1:0] LAYER,
    output logic [9:0]        LEDR
);
    localparam int unsigned COLS = CUBE_N * CUBE_N;
    localparam int unsigned LW   = cnt_width(CUBE_N);
    localparam int unsigned SW   = cnt_width(FRAME_HOLD);
    localparam int unsigned FW   = cnt_width(NUM_FRAMES);
    localparam int unsigned HW   = cnt_width(LAYER_HOLD + 1);

    logic clk, rst_n, unused_key3;
    assign clk         = CLOCK_50;
    assign rst_n       = KEY[0];
    assign unused_key3 = KEY[3];

    logic [1:0]        key_s0_q, key_s0_d, key_s1_q, key_s1_d, key_prev_q, key_prev_d;
    logic              start_p, stop_p;
    logic [1:0]        state_q, state_d;
    logic [LW-1:0]     layer_q, layer_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              oe_n_q, oe_n_d;
    logic [CUBE_N-1:0] layer_out_q, layer_out_d;
    logic [LEDR_W-1:0] ledr_q, ledr_d;
    logic              shift_start, shift_abort, shift_done_c, latch_done_c;
    logic [COLS-1:0]   shift_word;

    // Two-flop synchroniser plus falling-edge detect; index 0 is start, 1 is stop.
    always_comb begin
        key_s0_d   = KEY[2:1];
        key_s1_d   = key_s0_q;
        key_prev_d = key_s1_q;
    end
    assign start_p = key_prev_q[0] & ~key_s1_q[0];
    assign stop_p  = key_prev_q[1] & ~key_s1_q[1];

    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        scan_d      = scan_q;
        frame_d     = frame_q;
        hold_d      = hold_q;
        oe_n_d      = 1'b1;
        layer_out_d = layer_out_q;
        shift_start = 1'b0;
        shift_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                layer_out_d = '0;
                if (start_p && !stop_p) begin
                    state_d     = ST_SHIFT;
                    layer_d     = '0;
                    shift_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                layer_out_d = '0;
                if (shift_done_c) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (latch_done_c) begin
                    layer_out_d = CUBE_N'(1) << layer_q;
                    hold_d      = '0;
                    state_d     = ST_DISPLAY;
                end
            end
            default: begin
                if (hold_q == HW'(LAYER_HOLD)) begin
                    state_d     = ST_SHIFT;
                    shift_start = 1'b1;
                    if (layer_q == LW'(CUBE_N - 1)) begin
                        layer_d = '0;
                        if (scan_q == SW'(FRAME_HOLD - 1)) begin
                            scan_d  = '0;
                            frame_d = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + FW'(1);
                        end else begin
                            scan_d = scan_q + SW'(1);
                        end
                    end else begin
                        layer_d = layer_q + LW'(1);
                    end
                end else begin
                    oe_n_d = 1'b0;
                    hold_d = hold_q + HW'(1);
                end
            end
        endcase
        // Stop overrides everything while running; the frame is kept for the next start.
        if (state_q != ST_IDLE && stop_p) begin
            state_d     = ST_IDLE;
            oe_n_d      = 1'b1;
            layer_out_d = '0;
            layer_d     = '0;
            scan_d      = '0;
            frame_d     = frame_q;
            shift_start = 1'b0;
            shift_abort = 1'b1;
        end
        shift_word = {COLS{frame_lit(32'(frame_d), 32'(layer_d), CUBE_N)}};
        ledr_d     = {(state_d != ST_IDLE), 6'b0, 3'(frame_d)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s0_q    <= '1;
            key_s1_q    <= '1;
            key_prev_q  <= '1;
            state_q     <= ST_IDLE;
            layer_q     <= '0;
            scan_q      <= '0;
            frame_q     <= '0;
            hold_q      <= '0;
            oe_n_q      <= 1'b1;
            layer_out_q <= '0;
            ledr_q      <= '0;
        end else begin
            key_s0_q    <= key_s0_d;
            key_s1_q    <= key_s1_d;
            key_prev_q  <= key_prev_d;
            state_q     <= state_d;
            layer_q     <= layer_d;
            scan_q      <= scan_d;
            frame_q     <= frame_d;
            hold_q      <= hold_d;
            oe_n_q      <= oe_n_d;
            layer_out_q <= layer_out_d;
            ledr_q      <= ledr_d;
        end
    end

    led_cube_shifter #(
        .COLS    (COLS),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (shift_start),
        .abort        (shift_abort),
        .word         (shift_word),
        .ser          (SER),
        .srclk        (SRCLK),
        .rclk         (RCLK),
        .shift_done_c (shift_done_c),
        .latch_done_c (latch_done_c)
    );

    assign OE_N  = oe_n_q;
    assign LAYER = layer_out_q;
    assign LEDR  = ledr_q;

endmodule

// File: tb/tb_led_cube_multi_frame.sv
// Bench for led_cube_multi_frame: an event-level cube model (bits per latch, latched word,
// hold length, layer/scan/frame progression) checked every cycle, plus directed key scenarios.
module tb_led_cube_multi_frame;
    localparam int CUBE_N     = 8;
    localparam int NUM_FRAMES = 2;
    localparam int CLK_DIV    = 1;
    localparam int LAYER_HOLD = 4;
    localparam int FRAME_HOLD = 2;
    localparam int COLS       = CUBE_N * CUBE_N;

    logic        clk = 1'b0;
    logic [3:0]  key;
    logic        ser, srclk, rclk, oe_n;
    logic [7:0]  layer;
    logic [9:0]  ledr;

    always #5 clk = ~clk;

    led_cube_multi_frame #(
        .CUBE_N     (CUBE_N),
        .NUM_FRAMES (NUM_FRAMES),
        .CLK_DIV    (CLK_DIV),
        .LAYER_HOLD (LAYER_HOLD),
        .FRAME_HOLD (FRAME_HOLD)
    ) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SER      (ser),
        .SRCLK    (srclk),
        .RCLK     (rclk),
        .OE_N     (oe_n),
        .LAYER    (layer),
        .LEDR     (ledr)
    );

    int          checks = 0;
    int          errors = 0;
    int          m_frame = 0, m_layer = 0, m_scan = 0;
    bit          mon_en = 1'b0, abort_evt = 1'b0;
    logic [63:0] sh_word = '0, last_latched = '0;
    int          sh_bits = 0, low_cnt = 0, rclk_cnt = 0;
    logic        srclk_prev = 1'b0, rclk_prev = 1'b0, oe_prev = 1'b1;
    logic [7:0]  layer_prev = '0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] exp_word(input int f, input int l);
        return (l == f % CUBE_N) ? {64{1'b1}} : 64'h0;
    endfunction

    // Per-cycle comparison against the cube model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (abort_evt) begin
                abort_evt = 1'b0;
                sh_bits   = 0;
                low_cnt   = 0;
                rclk_cnt  = 0;
            end else begin
                if (srclk && !srclk_prev) begin
                    chk(oe_n == 1'b1, "oe_during_shift", 64'(oe_n), 64'd1);
                    sh_word = {sh_word[62:0], ser};
                    sh_bits++;
                end
                if (rclk && !rclk_prev) begin
                    chk(sh_bits == COLS, "bits_per_latch", 64'(sh_bits), 64'(COLS));
                    chk(sh_word == exp_word(m_frame, m_layer), "latched_word", sh_word,
                        exp_word(m_frame, m_layer));
                    last_latched = sh_word;
                    sh_bits      = 0;
                    rclk_cnt++;
                end
                if (!oe_n && oe_prev) begin
                    chk(rclk_cnt == 1, "one_rclk_per_layer", 64'(rclk_cnt), 64'd1);
                    rclk_cnt = 0;
                    low_cnt  = 0;
                end
                if (!oe_n) low_cnt++;
                if (oe_n && !oe_prev) begin
                    chk(low_cnt == LAYER_HOLD, "hold_len", 64'(low_cnt), 64'(LAYER_HOLD));
                    m_layer++;
                    if (m_layer == CUBE_N) begin
                        m_layer = 0;
                        m_scan++;
                        if (m_scan == FRAME_HOLD) begin
                            m_scan  = 0;
                            m_frame = (m_frame + 1) % NUM_FRAMES;
                        end
                    end
                end
            end
            chk(ledr[8:0] == {6'b0, 3'(m_frame)}, "ledr_frame", 64'(ledr[8:0]), 64'(m_frame));
            if (!ledr[9])
                chk({oe_n, layer, srclk, rclk} == {1'b1, 8'h00, 2'b00}, "idle_outputs",
                    64'({oe_n, layer, srclk, rclk}), 64'h400);
            if (!oe_n) begin
                chk(layer == 8'(1) << m_layer, "layer_onehot", 64'(layer), 64'(8'(1) << m_layer));
                chk(layer == layer_prev, "no_ghost", 64'(layer), 64'(layer_prev));
            end
        end
        srclk_prev = srclk;
        rclk_prev  = rclk;
        oe_prev    = oe_n;
        layer_prev = layer;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input bit start, input bit stop);
        key[1] = !start;
        key[2] = !stop;
        step();
        key[2:1] = 2'b11;
    endtask

    task automatic wait_oe(input logic val);
        bit found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            step();
            if (oe_n == val) found = 1'b1;
        end
        chk(found, "timeout_oe", 64'(found), 64'd1);
    endtask

    task automatic wait_bits(input int k);
        bit found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            step();
            if (sh_bits == k) found = 1'b1;
        end
        chk(found, "timeout_bits", 64'(found), 64'd1);
    endtask

    task automatic wait_frame(input int f);
        bit found = 1'b0;
        for (int n = 0; n < 20000 && !found; n++) begin
            step();
            if (m_frame == f) found = 1'b1;
        end
        chk(found, "timeout_frame", 64'(found), 64'd1);
    endtask

    task automatic start_run();
        bit found = 1'b0;
        press(1'b1, 1'b0);
        for (int n = 2; n <= 4 + CLK_DIV && !found; n++) begin
            step();
            if (srclk) found = 1'b1;
        end
        chk(found, "start_latency", 64'(found), 64'd1);
        chk(ledr[9] == 1'b1, "running_flag", 64'(ledr[9]), 64'd1);
    endtask

    task automatic stop_run(input bit start_too);
        bit found = 1'b0;
        press(start_too, 1'b1);
        for (int n = 0; n < 6 && !found; n++) begin
            step();
            if (!ledr[9]) found = 1'b1;
        end
        chk(found, "stop_latency", 64'(found), 64'd1);
        chk({oe_n, layer, srclk, rclk} == {1'b1, 8'h00, 2'b00}, "stop_outputs",
            64'({oe_n, layer, srclk, rclk}), 64'h400);
        m_layer   = 0;
        m_scan    = 0;
        abort_evt = 1'b1;
    endtask

    initial begin
        int k;
        key = 4'b1110;
        step();
        key[0]    = 1'b1;
        abort_evt = 1'b1;
        mon_en    = 1'b1;
        chk({ser, srclk, rclk, oe_n, layer, ledr} == 22'h040000, "reset_state",
            64'({ser, srclk, rclk, oe_n, layer, ledr}), 64'h040000);
        repeat (20) step();
        chk(ledr == 10'h000, "idle_hold", 64'(ledr), 64'h0);

        start_run();
        wait_oe(1'b0);
        chk(layer == 8'h01, "first_layer", 64'(layer), 64'h01);
        chk(last_latched == 64'hFFFF_FFFF_FFFF_FFFF, "first_word", last_latched,
            64'hFFFF_FFFF_FFFF_FFFF);
        wait_oe(1'b1);
        wait_oe(1'b0);
        chk(layer == 8'h02, "second_layer", 64'(layer), 64'h02);
        chk(last_latched == 64'h0, "second_word", last_latched, 64'h0);

        wait_frame(1);
        chk(ledr == 10'h201, "frame1_ledr", 64'(ledr), 64'h201);
        wait_oe(1'b0);
        chk(last_latched == 64'h0, "frame1_layer0", last_latched, 64'h0);
        wait_oe(1'b1);
        wait_oe(1'b0);
        chk({layer, last_latched} == {8'h02, 64'hFFFF_FFFF_FFFF_FFFF}, "frame1_layer1",
            64'(layer), 64'h02);
        wait_frame(0);
        chk(ledr == 10'h200, "frame_wrap", 64'(ledr), 64'h200);

        for (int it = 0; it < 4; it++) begin
            k = int'($urandom_range(1, 50));
            wait_bits(k);
            if ($urandom_range(0, 1) == 1) begin
                press(1'b1, 1'b0);
                wait_bits(k + 6);
            end
            stop_run(1'b0);
            repeat ($urandom_range(1, 20)) step();
            if (it == 1) begin
                press(1'b1, 1'b1);
                repeat (6) step();
                chk(ledr[9] == 1'b0, "idle_start_stop", 64'(ledr[9]), 64'd0);
            end
            start_run();
            repeat ($urandom_range(1, 12)) wait_oe(1'b0);
        end

        wait_bits(int'($urandom_range(1, 50)));
        stop_run(1'b1);

        start_run();
        wait_oe(1'b0);
        key[0] = 1'b0;
        step();
        key[0]    = 1'b1;
        m_frame   = 0;
        m_layer   = 0;
        m_scan    = 0;
        abort_evt = 1'b1;
        chk({ser, srclk, rclk, oe_n, layer, ledr} == 22'h040000, "reset_mid_display",
            64'({ser, srclk, rclk, oe_n, layer, ledr}), 64'h040000);
        repeat (10) step();
        chk({oe_n, ledr} == 11'h400, "idle_after_reset", 64'({oe_n, ledr}), 64'h400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
